seq_mul_param: RTL and testbench

//  Parametrised sequential shift-add multiplier, successor to the fixed 32-bit unsigned unit.
//  - Multiplies two WIDTH-bit operands, one multiplier bit per clock.
//  - Per-operation signed/unsigned mode; busy/ready handshake; product held until next result.
//  - Sits beside the ALU in the datapath for MUL/MULU-class operations.

---
 rtl/seq_mul_param.sv | 102 ++++++++++
 tb/tb_seq_mul_param.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/seq_mul_param.sv
// Parametrised shift-add multiplier: one multiplier bit per clock, signed or unsigned per operation.
// Signed operands are reduced to magnitudes up front and the sign is reapplied to the final product.
module seq_mul_param #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               run,
   input  logic               is_signed,
   input  logic [WIDTH-1:0]   multiplicand,
   input  logic [WIDTH-1:0]   multiplier,
   output logic               busy,
   output logic               ready,
   output logic [2*WIDTH-1:0] product
);

   typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

   localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

   state_e               state_q, state_d;
   logic                 sgn_q, sgn_d;
   logic [WIDTH-1:0]     mag_a_q, mag_a_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   product_q, product_d;
   logic                 ready_q, ready_d;

   logic                 neg_a, neg_b;
   logic [WIDTH-1:0]     mag_a_in, mag_b_in;
   logic [WIDTH:0]       sum;

   always_comb begin
      neg_a    = is_signed & multiplicand[WIDTH-1];
      neg_b    = is_signed & multiplier[WIDTH-1];
      mag_a_in = neg_a ? -multiplicand : multiplicand;
      mag_b_in = neg_b ? -multiplier : multiplier;
      // Carry out of the add lands in the top accumulator bit after the shift.
      sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? mag_a_q : '0)};
   end

   always_comb begin
      state_d   = state_q;
      sgn_d     = sgn_q;
      mag_a_d   = mag_a_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      product_d = product_q;
      ready_d   = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (run) begin
               sgn_d   = neg_a ^ neg_b;
               mag_a_d = mag_a_in;
               acc_d   = {{WIDTH{1'b0}}, mag_b_in};
               cnt_d   = '0;
               state_d = StCalc;
            end
         end
         StCalc: begin
            acc_d = {sum, acc_q[WIDTH-1:1]};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LastCnt) begin
               state_d = StDone;
            end
         end
         StDone: begin
            product_d = sgn_q ? -acc_q : acc_q;
            ready_d   = 1'b1;
            state_d   = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         sgn_q     <= 1'b0;
         mag_a_q   <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         product_q <= '0;
         ready_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         sgn_q     <= sgn_d;
         mag_a_q   <= mag_a_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         product_q <= product_d;
         ready_q   <= ready_d;
      end
   end

   assign busy    = (state_q != StIdle);
   assign ready   = ready_q;
   assign product = product_q;

endmodule

// File: tb/tb_seq_mul_param.sv
// Scoreboard bench for seq_mul_param at WIDTH=32 and WIDTH=8; drivers queue expected products,
// per-width monitors pop and compare on every ready pulse.
module tb_seq_mul_param;

   typedef struct {
      logic [63:0] prod;
      int          acc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        run32, s32, busy32, ready32;
   logic [31:0] a32, b32;
   logic [63:0] product32;
   logic        run8, s8, busy8, ready8;
   logic [7:0]  a8, b8;
   logic [15:0] product8;

   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   rdy32 = 0;
   int   rdy8 = 0;
   exp_t q32[$];
   exp_t q8[$];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   seq_mul_param #(.WIDTH(32)) u_dut32 (
      .clk          (clk),
      .rst_n        (rst_n),
      .run          (run32),
      .is_signed    (s32),
      .multiplicand (a32),
      .multiplier   (b32),
      .busy         (busy32),
      .ready        (ready32),
      .product      (product32)
   );

   seq_mul_param #(.WIDTH(8)) u_dut8 (
      .clk          (clk),
      .rst_n        (rst_n),
      .run          (run8),
      .is_signed    (s8),
      .multiplicand (a8),
      .multiplier   (b8),
      .busy         (busy8),
      .ready        (ready8),
      .product      (product8)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst_n === 1'b1 && ready32 === 1'b1) begin
         if (q32.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_ready32: got product 0x%0h expected no ready", product32);
         end else begin
            e = q32.pop_front();
            check("product32", product32, e.prod);
            check("latency32", 64'(cyc - e.acc), 64'd33);
         end
         rdy32++;
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (rst_n === 1'b1 && ready8 === 1'b1) begin
         if (q8.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_ready8: got product 0x%0h expected no ready", product8);
         end else begin
            e = q8.pop_front();
            check("product8", {48'd0, product8}, e.prod);
            check("latency8", 64'(cyc - e.acc), 64'd9);
         end
         rdy8++;
      end
   end

   // Issues one operation, then waits (bounded) for its ready; inject re-pulses run while busy.
   task automatic run_op(input bit w8, input logic [31:0] a, input logic [31:0] b, input bit s,
                         input logic [63:0] exp, input bit inject);
      int   target;
      exp_t e;
      bit   done;
      @(negedge clk);
      if (w8) begin
         a8 = a[7:0]; b8 = b[7:0]; s8 = s; run8 = 1'b1; target = rdy8 + 1;
      end else begin
         a32 = a; b32 = b; s32 = s; run32 = 1'b1; target = rdy32 + 1;
      end
      @(posedge clk);
      #1;
      e.prod = exp;
      e.acc  = cyc;
      if (w8) begin
         q8.push_back(e);
         run8 = 1'b0;
         check("busy8_after_run", {63'd0, busy8}, 64'd1);
      end else begin
         q32.push_back(e);
         run32 = 1'b0;
         check("busy32_after_run", {63'd0, busy32}, 64'd1);
      end
      done = 1'b0;
      for (int i = 1; i <= 60 && !done; i++) begin
         @(negedge clk);
         #1;
         if (!w8) begin
            if (inject && (i == 5 || i == 20)) begin
               run32 = 1'b1; a32 = 32'd9; b32 = 32'd9; s32 = 1'b0;
            end else begin
               run32 = 1'b0;
            end
         end
         done = w8 ? (rdy8 >= target) : (rdy32 >= target);
      end
      if (!done) begin
         total++;
         bad++;
         $display("FAIL timeout: got no ready within 60 cycles expected product 0x%0h", exp);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      run32 = 1'b0; s32 = 1'b0; a32 = '0; b32 = '0;
      run8  = 1'b0; s8  = 1'b0; a8  = '0; b8  = '0;
      repeat (3) @(negedge clk);
      check("reset_busy32", {63'd0, busy32}, 64'd0);
      check("reset_ready32", {63'd0, ready32}, 64'd0);
      check("reset_product32", product32, 64'd0);
      check("reset_product8", {48'd0, product8}, 64'd0);
      rst_n = 1'b1;

      run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 1'b0);
      run_op(1'b0, 32'hFFFF_FFFD, 32'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1, 1'b0);
      run_op(1'b0, 32'hFFFF_FFFD, 32'd5, 1'b0, 64'h0000_0004_FFFF_FFF1, 1'b0);
      run_op(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 1'b0);
      run_op(1'b0, 32'd0, 32'hFFFF_FFFF, 1'b1, 64'd0, 1'b0);
      run_op(1'b0, 32'h7FFF_FFFF, 32'hFFFF_FFFE, 1'b1, 64'hFFFF_FFFF_0000_0002, 1'b0);
      run_op(1'b0, 32'd123, 32'd456, 1'b0, 64'd56088, 1'b1);

      // Abort an operation with a one-cycle reset; it must never report.
      @(negedge clk);
      a32 = 32'd1000; b32 = 32'd1000; s32 = 1'b0; run32 = 1'b1;
      @(posedge clk);
      #1;
      run32 = 1'b0;
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_busy32", {63'd0, busy32}, 64'd0);
      check("abort_ready32", {63'd0, ready32}, 64'd0);
      check("abort_product32", product32, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      check("abort_idle_busy32", {63'd0, busy32}, 64'd0);
      run_op(1'b0, 32'h1234_5678, 32'h10, 1'b0, 64'h0000_0001_2345_6780, 1'b0);

      run_op(1'b1, 32'h80, 32'h7F, 1'b1, 64'hC080, 1'b0);
      run_op(1'b1, 32'hFF, 32'hFF, 1'b0, 64'hFE01, 1'b0);
      run_op(1'b1, 32'hFF, 32'hFF, 1'b1, 64'h0001, 1'b0);

      repeat (5) @(negedge clk);
      check("ready_count32", 64'(rdy32), 64'd8);
      check("ready_count8", 64'(rdy8), 64'd3);
      check("queue32_empty", 64'(q32.size()), 64'd0);
      check("queue8_empty", 64'(q8.size()), 64'd0);
      check("final_product32_held", product32, 64'h0000_0001_2345_6780);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
